mem_align_unit: RTL and testbench

- Sits directly downstream of the multicycle RV32I control FSM and its MAR/MDR/data_out registers; upstream of physical memory.
- Turns the FSM's level-held mem_read/mem_write requests plus funct3 into word-aligned physical memory transactions with byte enables and lane-shifted write data.
- Returns load data aligned to bit 0 and sign- or zero-extended, with a single-cycle mem_resp.
- Detects misaligned accesses and reports rmask/wmask for the RVFI monitor.

---
 rtl/mem_align_if.sv | 37 +++
 rtl/mem_align_unit.sv | 159 +++++++++++++++
 tb/tb_mem_align_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_align_if.sv
// Bus bundle between the multicycle control FSM, the alignment unit and physical memory.
// slave = alignment unit view; master = environment (control + memory) view.
interface mem_align_if;
   logic        mem_read;
   logic        mem_write;
   logic        ifetch;
   logic [2:0]  funct3;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_resp;
   logic [31:0] mem_rdata;
   logic        misaligned;
   logic        bus_error;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   logic [3:0]  pmem_byte_enable;
   logic [31:0] pmem_wdata;
   logic [31:0] pmem_rdata;
   logic        pmem_resp;

   modport slave (
      input  mem_read, mem_write, ifetch, funct3, mem_address, mem_wdata,
             pmem_rdata, pmem_resp,
      output mem_resp, mem_rdata, misaligned, bus_error, mem_rmask, mem_wmask,
             pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata
   );

   modport master (
      output mem_read, mem_write, ifetch, funct3, mem_address, mem_wdata,
             pmem_rdata, pmem_resp,
      input  mem_resp, mem_rdata, misaligned, bus_error, mem_rmask, mem_wmask,
             pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata
   );
endinterface

// File: rtl/mem_align_unit.sv
// Converts RV32I load/store/fetch requests into word-aligned physical memory cycles.
// Optional REQ timeout abort is enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; captures the access
// REQ   | physical strobe held until pmem_resp (or timeout)
// RESP  | mem_resp pulse, then back to IDLE
module mem_align_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   mem_align_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t      state;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        ifetch_q;
   logic        is_write_q;
   logic [3:0]  mask_q;

   logic [1:0]  req_off;
   logic        req_word;
   logic        req_half;
   logic [3:0]  req_mask;
   logic        req_mis;
   logic [31:0] req_wdata;
   logic [31:0] raw;
   logic [31:0] load_data;

   always_comb begin
      req_off   = bus.mem_address[1:0];
      req_word  = bus.ifetch || bus.funct3[1];
      req_half  = !req_word && bus.funct3[0];
      req_mask  = 4'b0001 << req_off;
      req_mis   = 1'b0;
      if (req_word) begin
         req_mask = 4'b1111;
         req_mis  = (req_off != 2'b00);
      end else if (req_half) begin
         req_mask = 4'b0011 << req_off;
         req_mis  = req_off[0];
      end
      req_wdata = bus.mem_wdata << {req_off, 3'b000};
   end

   // Load path works from the captured access, not the live control inputs.
   always_comb begin
      raw = bus.pmem_rdata >> {off_q, 3'b000};
      if (ifetch_q || f3_q[1])
         load_data = raw;
      else if (f3_q[0])
         load_data = f3_q[2] ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      else
         load_data = f3_q[2] ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign bus.bus_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= IDLE;
         off_q                <= '0;
         f3_q                 <= '0;
         ifetch_q             <= 1'b0;
         is_write_q           <= 1'b0;
         mask_q               <= '0;
         bus.mem_resp         <= 1'b0;
         bus.mem_rdata        <= '0;
         bus.misaligned       <= 1'b0;
         bus.mem_rmask        <= '0;
         bus.mem_wmask        <= '0;
         bus.pmem_read        <= 1'b0;
         bus.pmem_write       <= 1'b0;
         bus.pmem_address     <= '0;
         bus.pmem_byte_enable <= '0;
         bus.pmem_wdata       <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt                  <= '0;
         bus.bus_error        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.mem_write || bus.mem_read) begin
                  off_q      <= req_off;
                  f3_q       <= bus.funct3;
                  ifetch_q   <= bus.ifetch;
                  is_write_q <= bus.mem_write;
                  mask_q     <= req_mask;
                  if (req_mis) begin
                     state          <= RESP;
                     bus.mem_resp   <= 1'b1;
                     bus.misaligned <= 1'b1;
                     bus.mem_rdata  <= '0;
                     bus.mem_rmask  <= '0;
                     bus.mem_wmask  <= '0;
                  end else begin
                     state                <= REQ;
                     bus.pmem_read        <= !bus.mem_write;
                     bus.pmem_write       <= bus.mem_write;
                     bus.pmem_address     <= {bus.mem_address[31:2], 2'b00};
                     bus.pmem_byte_enable <= req_mask;
                     bus.pmem_wdata       <= req_wdata;
`ifdef MEM_TIMEOUT_EN
                     cnt                  <= '0;
`endif
                  end
               end
            end
            REQ: begin
               if (bus.pmem_resp) begin
                  state          <= RESP;
                  bus.mem_resp   <= 1'b1;
                  bus.pmem_read  <= 1'b0;
                  bus.pmem_write <= 1'b0;
                  bus.mem_rmask  <= is_write_q ? 4'b0000 : mask_q;
                  bus.mem_wmask  <= is_write_q ? mask_q : 4'b0000;
                  if (!is_write_q)
                     bus.mem_rdata <= load_data;
               end
`ifdef MEM_TIMEOUT_EN
               else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state          <= RESP;
                  bus.mem_resp   <= 1'b1;
                  bus.bus_error  <= 1'b1;
                  bus.pmem_read  <= 1'b0;
                  bus.pmem_write <= 1'b0;
                  bus.mem_rdata  <= '0;
                  bus.mem_rmask  <= '0;
                  bus.mem_wmask  <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end
            RESP: begin
               state          <= IDLE;
               bus.mem_resp   <= 1'b0;
               bus.misaligned <= 1'b0;
`ifdef MEM_TIMEOUT_EN
               bus.bus_error  <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_align_unit.sv
// Self-checking bench for mem_align_unit: directed table, randomized accesses, reset/idle corners.
module tb_mem_align_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_align_if bus ();

   mem_align_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      bit          wr;
      bit          ifetch;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          k;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic [31:0] exp_pw;
      bit          mis;
   } vec_t;

   int checks = 0;
   int errors = 0;
   logic [31:0] rdata_hold = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: access width in bytes, then plain arithmetic on offsets.
   function automatic int m_bytes(input bit ifetch, input logic [2:0] f3);
      if (ifetch || f3[1:0] == 2'd2) return 4;
      if (f3[1:0] == 2'd1) return 2;
      return 1;
   endfunction

   function automatic bit m_mis(input bit ifetch, input logic [2:0] f3, input logic [31:0] a);
      return (int'(a % 4) % m_bytes(ifetch, f3)) != 0;
   endfunction

   function automatic logic [3:0] m_mask(input bit ifetch, input logic [2:0] f3, input logic [31:0] a);
      int n = m_bytes(ifetch, f3);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_load(input bit ifetch, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] rd);
      int     n   = m_bytes(ifetch, f3);
      longint raw = longint'(rd) >> (8 * (a % 4));
      longint v;
      if (n == 4) return 32'(raw);
      v = raw % (longint'(1) << (8 * n));
      if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   task automatic idle_inputs();
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.ifetch      = 1'b0;
      bus.funct3      = 3'd0;
      bus.mem_address = '0;
      bus.mem_wdata   = '0;
      bus.pmem_rdata  = '0;
      bus.pmem_resp   = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      logic [31:0] exp_rd;
      @(negedge clk);
      bus.mem_write   = v.wr;
      bus.mem_read    = !v.wr;
      bus.ifetch      = v.ifetch;
      bus.funct3      = v.f3;
      bus.mem_address = v.addr;
      bus.mem_wdata   = v.wdata;
      bus.pmem_rdata  = v.rdata;
      bus.pmem_resp   = 1'b0;
      @(negedge clk);
      if (v.mis) begin
         chk({tag, " mis_strobe"}, {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
      end else begin
         for (int i = 1; i <= v.k; i++) begin
            chk({tag, " req_rd"}, {31'd0, bus.pmem_read}, {31'd0, !v.wr});
            chk({tag, " req_wr"}, {31'd0, bus.pmem_write}, {31'd0, v.wr});
            chk({tag, " req_be"}, {28'd0, bus.pmem_byte_enable}, {28'd0, v.be});
            chk({tag, " req_addr"}, bus.pmem_address, {v.addr[31:2], 2'b00});
            if (v.wr) chk({tag, " req_wdata"}, bus.pmem_wdata, v.exp_pw);
            chk({tag, " early_resp"}, {31'd0, bus.mem_resp}, 32'd0);
            bus.pmem_resp = (i == v.k);
            @(negedge clk);
         end
         bus.pmem_resp = 1'b0;
         chk({tag, " strobe_drop"}, {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
      end
      chk({tag, " resp"}, {31'd0, bus.mem_resp}, 32'd1);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      exp_rd = v.mis ? 32'd0 : (v.wr ? rdata_hold : v.exp_rd);
      chk({tag, " rdata"}, bus.mem_rdata, exp_rd);
      chk({tag, " misaligned"}, {31'd0, bus.misaligned}, {31'd0, v.mis});
      chk({tag, " bus_error"}, {31'd0, bus.bus_error}, 32'd0);
      chk({tag, " rmask"}, {28'd0, bus.mem_rmask}, (v.mis || v.wr) ? 32'd0 : {28'd0, v.be});
      chk({tag, " wmask"}, {28'd0, bus.mem_wmask}, (v.mis || !v.wr) ? 32'd0 : {28'd0, v.be});
      rdata_hold = exp_rd;
      @(negedge clk);
      chk({tag, " pulse"}, {31'd0, bus.mem_resp}, 32'd0);
   endtask

   vec_t tbl [11];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      logic [2:0] rd_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      //           wr ifet f3    addr           wdata          rdata          k  be       exp_rd         exp_pw         mis
      tbl[0]  = '{1'b0, 1'b1, 3'd0, 32'h00000064, 32'h0,         32'hDEADBEEF, 3, 4'b1111, 32'hDEADBEEF, 32'h0,         1'b0};
      tbl[1]  = '{1'b0, 1'b0, 3'd0, 32'h00000103, 32'h0,         32'h80FF7F01, 1, 4'b1000, 32'hFFFFFF80, 32'h0,         1'b0};
      tbl[2]  = '{1'b0, 1'b0, 3'd4, 32'h00000103, 32'h0,         32'h80FF7F01, 2, 4'b1000, 32'h00000080, 32'h0,         1'b0};
      tbl[3]  = '{1'b1, 1'b0, 3'd1, 32'h00000202, 32'h1234ABCD, 32'h0,         2, 4'b1100, 32'h0,         32'hABCD0000, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 3'd2, 32'h00000301, 32'h0,         32'h55555555, 1, 4'b0000, 32'h0,         32'h0,         1'b1};
      tbl[5]  = '{1'b0, 1'b0, 3'd1, 32'h00000102, 32'h0,         32'h80011234, 1, 4'b1100, 32'hFFFF8001, 32'h0,         1'b0};
      tbl[6]  = '{1'b0, 1'b0, 3'd5, 32'h00000102, 32'h0,         32'h80011234, 1, 4'b1100, 32'h00008001, 32'h0,         1'b0};
      tbl[7]  = '{1'b1, 1'b0, 3'd0, 32'h00000005, 32'h000000A5, 32'h0,         1, 4'b0010, 32'h0,         32'h0000A500, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 3'd1, 32'h00000001, 32'h0000FFFF, 32'h0,         1, 4'b0000, 32'h0,         32'h0,         1'b1};
      tbl[9]  = '{1'b0, 1'b0, 3'd2, 32'h00000008, 32'h0,         32'h12345678, 4, 4'b1111, 32'h12345678, 32'h0,         1'b0};
      tbl[10] = '{1'b0, 1'b0, 3'd5, 32'h00000003, 32'h0,         32'hFFFFFFFF, 1, 4'b0000, 32'h0,         32'h0,         1'b1};

      idle_inputs();
      #12;
      chk("reset mem_resp", {31'd0, bus.mem_resp}, 32'd0);
      chk("reset strobes", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
      chk("reset rdata", bus.mem_rdata, 32'd0);
      chk("reset masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

      // pmem_resp while idle must not produce a completion
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("idle pmem_resp", {30'd0, bus.mem_resp, bus.pmem_read | bus.pmem_write}, 32'd0);
      end
      bus.pmem_resp = 1'b0;

      // reset in the middle of a store
      @(negedge clk);
      bus.mem_write   = 1'b1;
      bus.funct3      = 3'd2;
      bus.mem_address = 32'h00000400;
      bus.mem_wdata   = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      chk("rst pre strobe", {31'd0, bus.pmem_write}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst async strobe", {31'd0, bus.pmem_write}, 32'd0);
      chk("rst async resp", {31'd0, bus.mem_resp}, 32'd0);
      idle_inputs();
      rdata_hold = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst no resp", {30'd0, bus.mem_resp, bus.pmem_write}, 32'd0);
      end
      rv = '{1'b0, 1'b0, 3'd2, 32'h00000400, 32'h0, 32'h0BADCAFE, 2, 4'b1111, 32'h0BADCAFE, 32'h0, 1'b0};
      apply_vec(rv, "post_rst lw");

      for (int n = 0; n < 60; n++) begin
         rv.wr     = ($urandom_range(0, 2) == 0);
         rv.ifetch = !rv.wr && ($urandom_range(0, 4) == 0);
         rv.f3     = rv.wr ? 3'($urandom_range(0, 2)) : rd_f3[$urandom_range(0, 4)];
         rv.addr   = $urandom;
         rv.wdata  = $urandom;
         rv.rdata  = $urandom;
         rv.k      = $urandom_range(1, 4);
         rv.mis    = m_mis(rv.ifetch, rv.f3, rv.addr);
         rv.be     = rv.mis ? 4'b0000 : m_mask(rv.ifetch, rv.f3, rv.addr);
         rv.exp_rd = m_load(rv.ifetch, rv.f3, rv.addr, rv.rdata);
         rv.exp_pw = 32'(longint'(rv.wdata) << (8 * (rv.addr % 4)));
         apply_vec(rv, $sformatf("rnd%0d", n));
      end

`ifdef MEM_TIMEOUT_EN
      begin
         int held = 0;
         @(negedge clk);
         bus.mem_read    = 1'b1;
         bus.funct3      = 3'd2;
         bus.mem_address = 32'h00000040;
         bus.pmem_rdata  = 32'h11111111;
         @(negedge clk);
         for (int i = 0; i < 20 && !bus.mem_resp; i++) begin
            if (bus.pmem_read) held++;
            @(negedge clk);
         end
         chk("to resp", {31'd0, bus.mem_resp}, 32'd1);
         bus.mem_read = 1'b0;
         chk("to held cycles", 32'(held), 32'd4);
         chk("to bus_error", {31'd0, bus.bus_error}, 32'd1);
         chk("to rdata", bus.mem_rdata, 32'd0);
         chk("to strobe", {31'd0, bus.pmem_read}, 32'd0);
         @(negedge clk);
         chk("to pulse", {30'd0, bus.mem_resp, bus.bus_error}, 32'd0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
